seq_scan_ctrl: RTL and testbench
================================

Name: seq_scan_ctrl

Overview:
Feed controller and scheduler for the serial pattern detector path. Accepts parallel words from an upstream requester over a valid/ready handshake and serializes them into a 1-bit stream. Runs a runtime-programmable overlapping pattern matcher on that stream. Counts matches and flags when a programmed threshold is reached, replacing fixed-pattern hard-coded FSMs with one configurable block.

Parameters:
DATA_W, 8, width of each input word serialized per transfer
PAT_MAX, 8, maximum pattern length in bits (2..16)
LEN_W, 4, width of cfg_len; must hold PAT_MAX
CNT_W, 8, width of match counter and threshold

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset
cfg_we  input  1  configuration write strobe
cfg_pat  input  PAT_MAX  pattern; bit [cfg_len-1] is the oldest/first bit, bit [0] the newest
cfg_len  input  LEN_W  pattern length in bits
cfg_thr  input  CNT_W  match-count threshold; 0 disables thr_hit
s_valid  input  1  upstream word valid
s_data  input  DATA_W  upstream word
s_ready  output  1  controller can accept a word this cycle
bit_out  output  1  current serial bit
bit_vld  output  1  bit_out valid this cycle
match  output  1  one-cycle pulse per pattern match
match_cnt  output  CNT_W  saturating match count
thr_hit  output  1  sticky: match_cnt reached cfg_thr
busy  output  1  serialization in progress

Behaviour:
- Reset (rst low, asynchronous): state=IDLE, pattern regs=0, len=0, thr=0, history=0, fill=0. All outputs 0 except s_ready=1.
- FSM states: IDLE, SHIFT.
- IDLE:
  - s_ready=1 unless cfg_we=1.
  - Handshake (s_valid & s_ready at a rising edge) loads the shift register and bit index=0, then goes to SHIFT.
- SHIFT:
  - busy=1, bit_vld=1.
  - bit_out = MSB of the shift register. DATA_W bits are emitted, one per cycle, MSB first. The first bit is valid the cycle after the accepting edge.
  - s_ready=1 only on the last bit cycle (index DATA_W-1). A handshake there reloads and stays in SHIFT, giving gap-free streaming. With no handshake there, the FSM returns to IDLE.
- Configuration:
  - cfg_we is honoured only in IDLE. In SHIFT it is ignored.
  - On write: latch pat/len/thr and clear history, fill, match_cnt and thr_hit.
  - cfg_len > PAT_MAX is clamped to PAT_MAX. cfg_len=0 disables matching.
  - If cfg_we and s_valid occur in the same IDLE cycle, cfg wins and s_ready=0.
- Matcher:
  - Each bit_vld cycle: history <= {history[PAT_MAX-2:0], bit_out}; fill increments and saturates at PAT_MAX.
  - A match occurs when fill_next >= len and the low len bits of history_next equal the low len bits of pat. match is registered: high the cycle after the completing bit.
  - Matches may overlap and cross word boundaries. History persists across IDLE gaps until the next cfg_we.
- Counter:
  - match_cnt increments on each match and saturates at 2^CNT_W-1.
  - thr_hit sets the cycle match_cnt becomes equal to a nonzero thr and stays set until cfg_we or reset.
- An asynchronous reset mid-SHIFT aborts the word. No partial bits are emitted afterwards.

Optional Feature:
SEQ_SCAN_LSB_FIRST_EN:
- Defined: words are serialized LSB first (bit_out = shift-register LSB, shift right).
- Undefined: MSB first as above.
- Matcher, handshake and timing are otherwise identical.

Test Plan:
- Overlapping match within one word: cfg pat=5'b10010, len=5, thr=2; send 0x92 (bits 1,0,0,1,0,0,1,0). Required: match pulses 6 and 9 cycles after the accepting edge; match_cnt=2; thr_hit=1 from the second pulse.
- Back-to-back streaming with a cross-word match: hold s_valid=1 with 0xFF then 0x00. Required: bit_vld continuous for 16 cycles with no gap, s_ready high only on cycles 8 and 16. For pat=2'b10, len=2: exactly one match, pulsing the cycle after bit 9.
- Configuration timing: assert cfg_we during SHIFT and confirm it is ignored. Assert cfg_we with s_valid in IDLE: config taken, s_ready=0, word accepted next cycle. Then cfg_len=12 with PAT_MAX=8: behaves as len=8. Then cfg_len=0: no matches on any data.
- Counter saturation: CNT_W=3, pat=1'b1, len=1; send 0xFF and 0xFF. Required: match_cnt stops at 7; with thr=0, thr_hit stays 0.
- Reset mid-word: rst low at bit 3 of 0xA5. Required: all outputs cleared immediately, s_ready=1 after release, no residual bits; match_cnt=0.
- SEQ_SCAN_LSB_FIRST_EN build: send 0x01 with pat=1'b1, len=1. Required: bit_out=1 in the first bit cycle and match the next cycle. In the default build the match comes on the cycle after the 8th bit.

Source files
------------

// File: rtl/seq_scan_ctrl.sv
// seq_scan_ctrl: accepts words over valid/ready, serializes them into a 1-bit
// stream and runs a programmable overlapping pattern matcher with a saturating
// match counter and a sticky threshold flag.
// Optional build macro: SEQ_SCAN_LSB_FIRST_EN serializes words LSB first.
module seq_scan_ctrl #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned PAT_MAX = 8,
  parameter int unsigned LEN_W   = 4,
  parameter int unsigned CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [PAT_MAX-1:0] cfg_pat,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic [CNT_W-1:0]   cfg_thr,
  input  logic               s_valid,
  input  logic [DATA_W-1:0]  s_data,
  output logic               s_ready,
  output logic               bit_out,
  output logic               bit_vld,
  output logic               match,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               thr_hit,
  output logic               busy
);

  localparam int unsigned IdxW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IdxW-1:0]  IdxLast = IdxW'(DATA_W - 1);
  localparam logic [LEN_W-1:0] LenMax  = LEN_W'(PAT_MAX);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e               state_q, state_d;
  logic [DATA_W-1:0]    shreg_q, shreg_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [PAT_MAX-1:0]   pat_q;
  logic [LEN_W-1:0]     len_q;
  logic [CNT_W-1:0]     thr_q;
  logic [PAT_MAX-1:0]   hist_q, hist_d;
  logic [LEN_W-1:0]     fill_q, fill_d;
  logic                 match_q, match_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 thr_hit_q, thr_hit_d;
  logic                 cfg_take;
  logic                 cur_bit;
  logic [PAT_MAX-1:0]   pat_mask;

`ifdef SEQ_SCAN_LSB_FIRST_EN
  assign cur_bit = shreg_q[0];
`else
  assign cur_bit = shreg_q[DATA_W-1];
`endif

  // Handshake / serializer FSM: next state, shift register and handshake outputs
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    idx_d    = idx_q;
    s_ready  = 1'b0;
    busy     = 1'b0;
    bit_vld  = 1'b0;
    cfg_take = 1'b0;
    unique case (state_q)
      StIdle: begin
        // A config write blocks the word for this cycle
        s_ready  = ~cfg_we;
        cfg_take = cfg_we;
        if (s_valid && !cfg_we) begin
          shreg_d = s_data;
          idx_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        busy    = 1'b1;
        bit_vld = 1'b1;
        if (idx_q == IdxLast) begin
          // Last bit: reload here for gap-free streaming
          s_ready = 1'b1;
          if (s_valid) begin
            shreg_d = s_data;
            idx_d   = '0;
          end else begin
            state_d = StIdle;
          end
        end else begin
`ifdef SEQ_SCAN_LSB_FIRST_EN
          shreg_d = {1'b0, shreg_q[DATA_W-1:1]};
`else
          shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
`endif
          idx_d   = idx_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Only the low len bits of the pattern take part in the compare
  always_comb begin
    pat_mask = '0;
    for (int unsigned i = 0; i < PAT_MAX; i++) begin
      pat_mask[i] = (LEN_W'(i) < len_q);
    end
  end

  // Matcher, counter and threshold next-state
  always_comb begin
    hist_d    = hist_q;
    fill_d    = fill_q;
    match_d   = 1'b0;
    cnt_d     = cnt_q;
    thr_hit_d = thr_hit_q;
    if (bit_vld) begin
      hist_d = {hist_q[PAT_MAX-2:0], cur_bit};
      fill_d = (fill_q == LenMax) ? fill_q : fill_q + 1'b1;
      match_d = (len_q != '0) && (fill_d >= len_q) && (((hist_d ^ pat_q) & pat_mask) == '0);
    end
    if (match_d && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (match_d && (thr_q != '0) && (cnt_d == thr_q)) begin
      thr_hit_d = 1'b1;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      shreg_q   <= '0;
      idx_q     <= '0;
      pat_q     <= '0;
      len_q     <= '0;
      thr_q     <= '0;
      hist_q    <= '0;
      fill_q    <= '0;
      match_q   <= 1'b0;
      cnt_q     <= '0;
      thr_hit_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      match_q <= match_d;
      if (cfg_take) begin
        pat_q     <= cfg_pat;
        len_q     <= (cfg_len > LenMax) ? LenMax : cfg_len;
        thr_q     <= cfg_thr;
        hist_q    <= '0;
        fill_q    <= '0;
        cnt_q     <= '0;
        thr_hit_q <= 1'b0;
      end else begin
        hist_q    <= hist_d;
        fill_q    <= fill_d;
        cnt_q     <= cnt_d;
        thr_hit_q <= thr_hit_d;
      end
    end
  end

  // Gate the stream bit so it reads 0 whenever no bit is being presented
  always_comb begin
    bit_out   = bit_vld & cur_bit;
    match     = match_q;
    match_cnt = cnt_q;
    thr_hit   = thr_hit_q;
  end

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Scoreboard bench for seq_scan_ctrl: stimulus pushes expected serial bits and
// match events; a negedge monitor pops and compares them as the DUT emits.
module tb_seq_scan_ctrl;

  localparam int DW = 8;
  localparam int PM = 8;
  localparam int LW = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cfg_we = 1'b0;
  logic [PM-1:0] cfg_pat = '0;
  logic [LW-1:0] cfg_len = '0;
  logic [CW-1:0] cfg_thr = '0;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_ready, bit_out, bit_vld, match, thr_hit, busy;
  logic [CW-1:0] match_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {int cyc; int val;} bit_t;
  typedef struct {int cyc; int cnt; int thr;} mt_t;
  bit_t exp_bits[$];
  mt_t  exp_m[$];
  int   rdy_cyc[$];

  seq_scan_ctrl #(.DATA_W(DW), .PAT_MAX(PM), .LEN_W(LW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pat(cfg_pat), .cfg_len(cfg_len),
    .cfg_thr(cfg_thr), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .bit_out(bit_out), .bit_vld(bit_vld), .match(match), .match_cnt(match_cnt),
    .thr_hit(thr_hit), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int emit_bit(input logic [7:0] w, input int k);
`ifdef SEQ_SCAN_LSB_FIRST_EN
    return int'(w[k]);
`else
    return int'(w[7-k]);
`endif
  endfunction

  task automatic push_m(input int c, input int n, input int t);
    mt_t m;
    m.cyc = c; m.cnt = n; m.thr = t;
    exp_m.push_back(m);
  endtask

  // Monitor: pops expectations whenever the DUT presents a bit or a match
  always @(negedge clk) begin
    bit_t b;
    mt_t  m;
    if (rst) begin
      if (bit_vld) begin
        chk("busy_with_bit", int'(busy), 1);
        if (s_ready) rdy_cyc.push_back(cyc);
        if (exp_bits.size() == 0) begin
          checks++; errors++;
          $display("FAIL extra_bit: bit_vld high with none expected (cycle %0d)", cyc);
        end else begin
          b = exp_bits.pop_front();
          chk("bit_cycle", cyc, b.cyc);
          chk("bit_value", int'(bit_out), b.val);
        end
      end
      if (match) begin
        if (exp_m.size() == 0) begin
          checks++; errors++;
          $display("FAIL extra_match: match pulse with none expected (cycle %0d)", cyc);
        end else begin
          m = exp_m.pop_front();
          chk("match_cycle", cyc, m.cyc);
          chk("match_cnt", int'(match_cnt), m.cnt);
          chk("thr_hit_at_match", int'(thr_hit), m.thr);
        end
      end
    end
  end

  // Called at posedge+1; config lands on the next edge
  task automatic do_cfg(input logic [7:0] p, input logic [3:0] l, input logic [2:0] t);
    cfg_pat = p; cfg_len = l; cfg_thr = t; cfg_we = 1'b1;
    @(posedge clk); #1 cfg_we = 1'b0;
  endtask

  task automatic send(input logic [7:0] w, input bit hold, output int acc);
    bit   done = 1'b0;
    bit_t b;
    acc = -1;
    s_data = w; s_valid = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (s_ready) begin
        @(posedge clk); #1;
        acc = cyc;
        done = 1'b1;
        for (int k = 0; k < 8; k++) begin
          b.cyc = acc + k; b.val = emit_bit(w, k);
          exp_bits.push_back(b);
        end
      end
    end
    if (!hold) s_valid = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL accept_timeout: word %0h never accepted", w);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int a, a2, ccyc;
    // Reset state
    #12;
    chk("rst_s_ready", int'(s_ready), 1);
    chk("rst_bit_vld", int'(bit_vld), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_match", int'(match), 0);
    chk("rst_cnt", int'(match_cnt), 0);
    chk("rst_thr_hit", int'(thr_hit), 0);
    @(posedge clk); #1 rst = 1'b1;
    idle(1);

    // Overlapping match in one word: 0x92 with pattern 10010
    do_cfg(8'b10010, 4'd5, 3'd2);
    send(8'h92, 1'b0, a);
`ifdef SEQ_SCAN_LSB_FIRST_EN
    push_m(a + 6, 1, 0);
    idle(12);
    chk("t1_cnt", int'(match_cnt), 1);
    chk("t1_thr", int'(thr_hit), 0);
`else
    push_m(a + 5, 1, 0);
    push_m(a + 8, 2, 1);
    idle(12);
    chk("t1_cnt", int'(match_cnt), 2);
    chk("t1_thr", int'(thr_hit), 1);
`endif

    // Gap-free streaming, cross-word match of 10
    do_cfg(8'b10, 4'd2, 3'd0);
    rdy_cyc.delete();
    send(8'hFF, 1'b1, a);
    send(8'h00, 1'b0, a2);
    push_m(a + 9, 1, 0);
    idle(12);
    chk("t2_gapfree", a2, a + 8);
    chk("t2_ready_count", rdy_cyc.size(), 2);
    if (rdy_cyc.size() == 2) begin
      chk("t2_ready_first", rdy_cyc[0], a + 7);
      chk("t2_ready_second", rdy_cyc[1], a + 15);
    end
    chk("t2_cnt", int'(match_cnt), 1);

    // cfg_we during SHIFT is ignored
    do_cfg(8'b1, 4'd1, 3'd0);
    send(8'h81, 1'b0, a);
    push_m(a + 1, 1, 0);
    push_m(a + 8, 2, 0);
    idle(2);
    cfg_pat = 8'h00; cfg_len = 4'd0; cfg_thr = 3'd5; cfg_we = 1'b1;
    @(negedge clk);
    chk("t3_shift_ready", int'(s_ready), 0);
    @(posedge clk); #1 cfg_we = 1'b0;
    idle(12);
    chk("t3_cnt_kept", int'(match_cnt), 2);

    // cfg_we with s_valid in IDLE: config wins, word taken next cycle
    cfg_pat = 8'b11; cfg_len = 4'd2; cfg_thr = 3'd1; cfg_we = 1'b1;
    s_data = 8'h3C; s_valid = 1'b1;
    @(negedge clk);
    chk("t3_ready_low_cfg", int'(s_ready), 0);
    ccyc = cyc;
    @(posedge clk); #1 cfg_we = 1'b0;
    @(negedge clk);
    chk("t3_ready_after_cfg", int'(s_ready), 1);
    chk("t3_cnt_cleared", int'(match_cnt), 0);
    @(posedge clk); #1;
    a = cyc; s_valid = 1'b0;
    chk("t3_accept_cycle", a, ccyc + 2);
    for (int k = 0; k < 8; k++) begin
      bit_t b;
      b.cyc = a + k; b.val = emit_bit(8'h3C, k);
      exp_bits.push_back(b);
    end
    push_m(a + 4, 1, 1);
    push_m(a + 5, 2, 1);
    push_m(a + 6, 3, 1);
    idle(12);

    // cfg_len above PAT_MAX behaves as PAT_MAX
    do_cfg(8'hF0, 4'd12, 3'd0);
    send(8'h0F, 1'b0, a);
`ifdef SEQ_SCAN_LSB_FIRST_EN
    push_m(a + 8, 1, 0);
`endif
    idle(12);
    send(8'h0F, 1'b0, a2);
`ifdef SEQ_SCAN_LSB_FIRST_EN
    push_m(a2 + 8, 2, 0);
    idle(12);
    chk("t3_clamp_cnt", int'(match_cnt), 2);
`else
    push_m(a2 + 4, 1, 0);
    idle(12);
    chk("t3_clamp_cnt", int'(match_cnt), 1);
`endif

    // cfg_len = 0 disables matching
    do_cfg(8'h00, 4'd0, 3'd0);
    send(8'h00, 1'b0, a);
    send(8'hFF, 1'b0, a);
    idle(12);
    chk("t3_len0_cnt", int'(match_cnt), 0);

    // Counter saturation at 7, thr=0 keeps thr_hit low
    do_cfg(8'b1, 4'd1, 3'd0);
    send(8'hFF, 1'b1, a);
    for (int k = 0; k < 8; k++) push_m(a + 1 + k, (k + 1 > 7) ? 7 : k + 1, 0);
    send(8'hFF, 1'b0, a2);
    for (int k = 0; k < 8; k++) push_m(a2 + 1 + k, 7, 0);
    idle(12);
    chk("t4_sat_cnt", int'(match_cnt), 7);
    chk("t4_thr_off", int'(thr_hit), 0);

    // Asynchronous reset at bit 3 of 0xA5
    do_cfg(8'b1, 4'd1, 3'd0);
    send(8'hA5, 1'b0, a);
    push_m(a + 1, 1, 0);
    push_m(a + 3, 2, 0);
    for (int i = 0; i < 20 && cyc != a + 3; i++) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    exp_bits.delete();
    chk("t5_bit_vld", int'(bit_vld), 0);
    chk("t5_bit_out", int'(bit_out), 0);
    chk("t5_busy", int'(busy), 0);
    chk("t5_match", int'(match), 0);
    chk("t5_cnt", int'(match_cnt), 0);
    chk("t5_s_ready_in_rst", int'(s_ready), 1);
    idle(2);
    rst = 1'b1;
    idle(12);
    chk("t5_s_ready_after", int'(s_ready), 1);
    chk("t5_cnt_after", int'(match_cnt), 0);

    // Bit order: 0x01 with pattern 1
    do_cfg(8'b1, 4'd1, 3'd0);
    send(8'h01, 1'b0, a);
`ifdef SEQ_SCAN_LSB_FIRST_EN
    push_m(a + 1, 1, 0);
`else
    push_m(a + 8, 1, 0);
`endif
    idle(12);
    chk("t6_cnt", int'(match_cnt), 1);

    idle(4);
    chk("bits_outstanding", exp_bits.size(), 0);
    chk("matches_outstanding", exp_m.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
